axis_switch_single_master: RTL

- N-to-1 AXI-Stream arbiter/merger with round-robin arbitration.
- Sits directly upstream of the 1-to-N dest-routed switch (axis_switch_single_slave); the pair forms one crossbar column.
- Grants one slave at a time and holds the grant for one beat (HAS_LAST=0) or one full packet (HAS_LAST=1).
- Data path is pass-through from the granted slave; only the grant is registered.

---
 rtl/axis_switch_single_master.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axis_switch_single_master.sv
// N-to-1 AXI-Stream merger with round-robin arbitration.
// The grant is registered and held for one beat or one packet; the data path is a pass-through mux.
module axis_switch_single_master #(
    parameter int NSLAVES      = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int HAS_DEST     = 0,
    parameter int HAS_ID       = 0,
    parameter int HAS_LAST     = 0,
    parameter int ID_WIDTH     = 1,
    parameter int DEST_WIDTH   = 1,
    parameter int ID_FROM_PORT = 0
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NSLAVES-1:0]              s_valid,
    output logic [NSLAVES-1:0]              s_ready,
    input  logic [NSLAVES*DATA_WIDTH-1:0]   s_data,
    input  logic [NSLAVES*DEST_WIDTH-1:0]   s_dest,
    input  logic [NSLAVES*ID_WIDTH-1:0]     s_id,
    input  logic [NSLAVES-1:0]              s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [DEST_WIDTH-1:0]           m_dest,
    output logic [ID_WIDTH-1:0]             m_id,
    output logic                            m_last
);

    localparam int SELW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    logic unused_fields;
    assign unused_fields = ^{s_dest, s_id};

    generate
        if (NSLAVES == 1) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = ^{aclk, aresetn};

            assign m_valid = s_valid[0];
            assign s_ready = m_ready;
            assign m_data  = s_data;
            assign m_last  = s_last[0];
            assign m_dest  = (HAS_DEST != 0) ? s_dest : '0;
            assign m_id    = (HAS_ID != 0 && ID_FROM_PORT == 0) ? s_id : '0;
        end else begin : g_arb
            typedef enum logic {IDLE, TRANSACTION} state_t;

            state_t                state;
            logic [SELW-1:0]       sel;
            logic [SELW-1:0]       ptr;
            logic [SELW-1:0]       scan_sel;
            logic                  scan_hit;
            logic                  sel_valid;
            logic                  sel_last;
            logic [DATA_WIDTH-1:0] sel_data;
            logic [DEST_WIDTH-1:0] sel_dest;
            logic [ID_WIDTH-1:0]   sel_id;
            logic                  busy;
            logic                  done;

            assign busy = (state == TRANSACTION);

            // Two passes (k >= ptr, then k < ptr) give the wrapped priority order without modulo arithmetic.
            always_comb begin
                scan_hit = 1'b0;
                scan_sel = ptr;
                for (int unsigned k = 0; k < NSLAVES; k++) begin
                    if (!scan_hit && s_valid[k] && k >= 32'(ptr)) begin
                        scan_hit = 1'b1;
                        scan_sel = SELW'(k);
                    end
                end
                for (int unsigned k = 0; k < NSLAVES; k++) begin
                    if (!scan_hit && s_valid[k] && k < 32'(ptr)) begin
                        scan_hit = 1'b1;
                        scan_sel = SELW'(k);
                    end
                end
            end

            always_comb begin
                sel_valid = 1'b0;
                sel_last  = 1'b0;
                sel_data  = '0;
                sel_dest  = '0;
                sel_id    = '0;
                s_ready   = '0;
                for (int unsigned k = 0; k < NSLAVES; k++) begin
                    if (sel == SELW'(k)) begin
                        sel_valid  = s_valid[k];
                        sel_last   = s_last[k];
                        sel_data   = s_data[k*DATA_WIDTH +: DATA_WIDTH];
                        sel_dest   = s_dest[k*DEST_WIDTH +: DEST_WIDTH];
                        sel_id     = s_id[k*ID_WIDTH +: ID_WIDTH];
                        s_ready[k] = busy && m_ready;
                    end
                end
            end

            assign m_valid = busy && sel_valid;
            assign m_data  = sel_data;
            assign m_last  = sel_last;
            assign m_dest  = (HAS_DEST != 0) ? sel_dest : '0;
            assign m_id    = (HAS_ID == 0)       ? '0 :
                             (ID_FROM_PORT != 0) ? ID_WIDTH'(sel) : sel_id;
            assign done    = m_valid && m_ready && ((HAS_LAST == 0) || sel_last);

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    state <= IDLE;
                    sel   <= '0;
                    ptr   <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (scan_hit) begin
                                sel   <= scan_sel;
                                state <= TRANSACTION;
                            end
                        end
                        TRANSACTION: begin
                            if (done) begin
                                state <= IDLE;
                                ptr   <= (sel == SELW'(NSLAVES - 1)) ? '0 : sel + 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    endgenerate

endmodule
